stream_fifo_src_arbiter: RTL
============================

# stream_fifo_src_arbiter

Round-robin arbiter that shares the write port of one SRAM-backed stream FIFO between `NUM_REQ` requesters. Each requester is limited to `QUOTA` entries resident in the FIFO, so one source cannot fill it and starve the others. The FIFO consumer returns a release per popped entry, tagged with the source ID. The block sits directly in front of the shared FIFO's write handshake.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 32, payload width
- `QUOTA`, 2, max entries per source resident in FIFO (≥1)
- `ID_WIDTH`, $clog2(NUM_REQ), source ID width (derived)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `req_valid_i`  in  NUM_REQ  per-source valid
- `req_ready_o`  out  NUM_REQ  per-source ready (one-hot or zero)
- `req_data_i`  in  NUM_REQ*DATA_WIDTH  packed payloads; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- `fifo_w_valid_o`  out  1  write valid to FIFO
- `fifo_w_ready_i`  in  1  FIFO write ready
- `fifo_w_data_o`  out  DATA_WIDTH  selected payload
- `fifo_w_src_o`  out  ID_WIDTH  selected source ID, stored alongside data
- `rel_valid_i`  in  1  consumer popped one entry
- `rel_src_i`  in  ID_WIDTH  source ID of popped entry
- `inflight_o`  out  NUM_REQ  bit i set when credit count of source i is nonzero
- `err_o`  out  1  sticky: release to a source with count 0, or `rel_src_i` ≥ NUM_REQ

## Operation
- Per-source credit counter `cnt[i]`, width $clog2(QUOTA+1). Eligible(i) = `req_valid_i[i]` && `cnt[i]` < QUOTA.
- Rotating priority pointer `ptr` (ID_WIDTH bits). Winner = first eligible index scanning `ptr`, `ptr+1`, …, wrapping at NUM_REQ-1 → 0.
- FSM with two states.
  - IDLE: `fifo_w_valid_o` = any eligible. Data and src come from the winner. `req_ready_o[winner]` = `fifo_w_ready_i`.
    - Push with ready=1: stay in IDLE, `ptr` ← winner+1 (wraps).
    - Valid with ready=0: register `lock_id` ← winner, go to LOCKED.
  - LOCKED: output is driven from `lock_id` only, regardless of other eligibility. `fifo_w_valid_o` = `req_valid_i[lock_id]`. Requesters must hold valid/data until accepted.
    - Push: `ptr` ← `lock_id`+1, go to IDLE.
    - Quota is not rechecked in LOCKED. Counts only fall while locked, so the locked source stays within quota.
- Push from source s: `cnt[s]`+1. Valid release for s: `cnt[s]`-1.
  - Push and release on the same source in the same cycle: count unchanged.
  - Push and release on different sources: both apply.
- Invalid release (count 0 or ID out of range): no counter changes, `err_o` ← 1 (sticky until reset).
- If no source is eligible: `fifo_w_valid_o`=0, `req_ready_o`=0, `ptr` unchanged.

## Timing
- Reset, checked the cycle after `rst` is sampled high:
  - FSM=IDLE, `ptr`=0, all `cnt`=0, `lock_id`=0, `err_o`=0.
  - Outputs: `fifo_w_valid_o`=0, `req_ready_o`=0, `inflight_o`=0, `fifo_w_data_o`=0, `fifo_w_src_o`=0.
- Reset mid-transfer drops the lock and all credits. The FIFO must be reset in the same cycle.
- Valid, data, src and ready paths are combinational: zero-cycle latency from `req_valid_i` to `fifo_w_valid_o`.
- Eligibility uses registered `cnt`.
  - A release frees a slot for arbitration starting the next cycle.
  - A push at quota-1 makes the source ineligible starting the next cycle.
- `req_ready_o` has at most one bit set, and only in a cycle where `fifo_w_valid_o` && `fifo_w_ready_i`.
- Back-to-back pushes from different sources are allowed, one per cycle, with no bubble.
- `inflight_o` and `err_o` are combinational decodes of registered state, so they update the cycle after the event.

## Test plan
- **Round-robin fairness.** NUM_REQ=4, all valid, ready=1, no releases, QUOTA=2. Required grant order: 0,1,2,3,0,1,2,3. After that `fifo_w_valid_o`=0 and all `inflight_o`=4'b1111.
- **Lock under backpressure.** Sources 1 and 2 valid, ready=0 for 3 cycles. Output stays src=1 with data stable. Raising source 3 valid does not change the grant. When ready=1, source 1 is accepted, then source 2 next cycle.
- **Quota and release.** Only source 0 valid, QUOTA=2, ready=1. Two pushes, then `fifo_w_valid_o`=0. Issue release src=0. Exactly one cycle later one more push occurs; `cnt[0]` returns to 2.
- **Simultaneous push and release.** Same source with `cnt`=1: count stays 1. Push on source 2 with release on source 0: `cnt[2]`+1 and `cnt[0]`-1.
- **Invalid release.** Release src=3 with `cnt[3]`=0: `err_o`=1 next cycle and stays 1; all counts unchanged.
- **Reset mid-lock.** In LOCKED on src=2 with `cnt`={1,2,0,1}, assert `rst` for one cycle. Next cycle all outputs are 0. With all sources valid, the first grant after reset goes to source 0.

Source files
------------

// File: rtl/stream_fifo_src_arbiter.sv
// rtl/stream_fifo_src_arbiter.sv - quota-limited round-robin arbiter for a shared stream FIFO write port
//
// Purpose:
//   Shares the write handshake of one stream FIFO between NUM_REQ sources.
//   Each source may have at most QUOTA entries resident in the FIFO. The
//   FIFO consumer returns one release per popped entry, tagged with the
//   source ID, which hands the credit back to that source. Once a write is
//   offered and stalled by the FIFO, the grant is locked to that source until
//   the entry is accepted. This keeps the write side stable under backpressure.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_valid_i     - per-source valid
//   req_ready_o     - per-source ready, at most one bit set, only on a push
//   req_data_i      - packed payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_w_valid_o  - write valid towards the FIFO
//   fifo_w_ready_i  - FIFO write ready
//   fifo_w_data_o   - payload of the selected source (zero when not valid)
//   fifo_w_src_o    - ID of the selected source (zero when not valid)
//   rel_valid_i     - consumer popped one entry
//   rel_src_i       - source ID of the popped entry
//   inflight_o      - bit i set while source i has entries resident
//   err_o           - sticky: release to a source holding no credit or out-of-range ID

module stream_fifo_src_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QUOTA      = 2,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          fifo_w_valid_o,
    input  logic                          fifo_w_ready_i,
    output logic [DATA_WIDTH-1:0]         fifo_w_data_o,
    output logic [ID_WIDTH-1:0]           fifo_w_src_o,
    input  logic                          rel_valid_i,
    input  logic [ID_WIDTH-1:0]           rel_src_i,
    output logic [NUM_REQ-1:0]            inflight_o,
    output logic                          err_o
);

    localparam int CNT_W = $clog2(QUOTA + 1);
    localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] lock_id_q;
    logic [CNT_W-1:0]    cnt_q [NUM_REQ];
    logic [CNT_W-1:0]    cnt_d [NUM_REQ];
    logic                err_q;

    logic [NUM_REQ-1:0]  eligible;
    logic                any_elig;
    logic [ID_WIDTH-1:0] win_id;
    logic [ID_WIDTH-1:0] sel_id;
    logic                w_valid;
    logic                push;
    logic [NUM_REQ-1:0]  push_vec;
    logic [NUM_REQ-1:0]  rel_dec;
    logic                rel_hit;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        if (int'(id) == NUM_REQ - 1) begin
            return '0;
        end
        return id + ID_WIDTH'(1);
    endfunction

    // Eligibility looks only at registered credit counts, so a release or a
    // push changes arbitration from the following cycle on.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < QUOTA_C);
        end
    end

    // Round-robin scan starting at ptr_q; the first eligible index wins.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        any_elig = 1'b0;
        win_id   = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                win_id   = idx;
            end
        end
    end

    // While locked the output follows lock_id_q only; quota is not rechecked
    // because counts can only fall during the lock.
    always_comb begin
        if (state_q == S_LOCKED) begin
            sel_id  = lock_id_q;
            w_valid = req_valid_i[lock_id_q];
        end else begin
            sel_id  = win_id;
            w_valid = any_elig;
        end
    end

    assign push           = w_valid && fifo_w_ready_i;
    assign fifo_w_valid_o = w_valid;
    assign fifo_w_src_o   = w_valid ? sel_id : '0;
    assign fifo_w_data_o  = w_valid ? req_data_i[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign req_ready_o    = push_vec;

    // Per-source push/release decode. A release is honoured only for an
    // in-range ID whose count is nonzero; anything else flags the error.
    always_comb begin
        push_vec = '0;
        rel_dec  = '0;
        rel_hit  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            push_vec[i] = push && (sel_id == ID_WIDTH'(i));
            if (rel_valid_i && (rel_src_i == ID_WIDTH'(i)) && (cnt_q[i] != '0)) begin
                rel_dec[i] = 1'b1;
                rel_hit    = 1'b1;
            end
        end
    end

    // Push and release on the same source cancel; otherwise each applies.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push_vec[i] && !rel_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rel_dec[i] && !push_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inflight_o[i] = (cnt_q[i] != '0);
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        if (fifo_w_ready_i) begin
                            ptr_q <= next_id(win_id);
                        end else begin
                            lock_id_q <= win_id;
                            state_q   <= S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (push) begin
                        ptr_q   <= next_id(lock_id_q);
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end

            if (rel_valid_i && !rel_hit) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
